alt_run_monitor: RTL

//  Downstream consumer of the alternating-0s/1s detector's 1-bit match flag z.

---
 rtl/alt_mon_pkg.sv | 15 +
 rtl/alt_run_monitor_sat_counter.sv | 26 ++
 rtl/alt_run_monitor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alt_mon_pkg.sv
// Shared types and default parameters for the alternating-run monitor.
package alt_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        ALARM = 2'b10,
        HOLD  = 2'b11
    } alt_mon_state_t;

    localparam int CNT_W_DEF    = 8;
    localparam int THRESH_DEF   = 4;
    localparam int HOLD_CYC_DEF = 3;

endpackage

// File: rtl/alt_run_monitor_sat_counter.sv
// Saturating counter: clear beats load-1, load-1 beats increment; holds at 2**W-1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (load1)
            q <= W'(1);
        else if (inc && q != MAX)
            q <= q + W'(1);
    end

endmodule

// File: rtl/alt_run_monitor.sv
// Run-length / alarm monitor for the detector match flag z_in.
// Build option: define ALT_MON_STICKY_EN to give alarm_seen a sticky flop.
module alt_run_monitor
    import alt_mon_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int THRESH   = THRESH_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z_in,
    input  logic             clr,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] max_run,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             alarm,
    output logic             alarm_pulse,
    output logic             alarm_seen
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    alt_mon_state_t   state, state_nxt;
    logic [HW-1:0]    hold_cnt, hold_nxt;
    logic [CNT_W-1:0] run_plus, run_len_nxt;
    logic             run_start, run_inc, run_clr;
    logic             pulse_nxt, alarm_nxt;

    assign run_plus = (run_len == CNT_MAX) ? run_len : run_len + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Threshold is checked against the incremented length so the alarm
    // rises at the same edge that run_len reaches THRESH.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (z_in) state_nxt = RUN;
                RUN:     if (!z_in) state_nxt = IDLE;
                         else if (run_plus == CNT_W'(THRESH)) state_nxt = ALARM;
                ALARM:   if (!z_in) state_nxt = HOLD;
                HOLD:    if (z_in) state_nxt = RUN;
                         else if (hold_cnt == '0) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        run_start = !clr && z_in && (state == IDLE || state == HOLD);
        run_inc   = !clr && z_in && (state == RUN  || state == ALARM);
        run_clr   = clr || !z_in;
        pulse_nxt = (state == RUN) && (state_nxt == ALARM);
        alarm_nxt = (state_nxt == ALARM) || (state_nxt == HOLD);

        run_len_nxt = run_len;
        if (run_clr)        run_len_nxt = '0;
        else if (run_start) run_len_nxt = CNT_W'(1);
        else if (run_inc)   run_len_nxt = run_plus;

        hold_nxt = hold_cnt;
        if (clr)
            hold_nxt = '0;
        else if (state == ALARM && !z_in)
            hold_nxt = HW'(HOLD_CYC - 1);
        else if (state == HOLD && !z_in && hold_cnt != '0)
            hold_nxt = hold_cnt - HW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt    <= '0;
            alarm       <= 1'b0;
            alarm_pulse <= 1'b0;
            max_run     <= '0;
        end else begin
            hold_cnt    <= hold_nxt;
            alarm       <= alarm_nxt;
            alarm_pulse <= pulse_nxt;
            if (clr)
                max_run <= '0;
            else if (run_len_nxt > max_run)
                max_run <= run_len_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (run_clr),
        .load1 (run_start),
        .inc   (run_inc),
        .q     (run_len)
    );

    sat_counter #(.W(CNT_W)) u_evt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .load1 (1'b0),
        .inc   (run_start),
        .q     (evt_cnt)
    );

`ifdef ALT_MON_STICKY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            alarm_seen <= 1'b0;
        else if (clr)
            alarm_seen <= 1'b0;
        else if (pulse_nxt)
            alarm_seen <= 1'b1;
    end
`else
    assign alarm_seen = 1'b0;
`endif

endmodule
